// File: rtl/switch_event_queue.sv
// switch_event_queue: converts net level changes of debounced switches into {index, level}
// events, lowest pending index first, buffered in a first-word-fall-through FIFO.
module switch_event_queue #(
    parameter int INPUTS = 16,
    parameter int IDX_W  = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [INPUTS-1:0] i_switch_db,
    output logic              o_ev_valid,
    input  logic              i_ev_ready,
    output logic [IDX_W-1:0]  o_ev_index,
    output logic              o_ev_level,
    output logic [CNT_W-1:0]  o_ev_count,
    output logic [INPUTS-1:0] o_state
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [INPUTS-1:0] r_cur, r_reported, w_pending;
    logic [IDX_W:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd, r_wr;
    logic [CNT_W-1:0]  r_count;
    logic [IDX_W-1:0]  w_sel;
    logic              w_valid, w_pop, w_push;

    // A switch is pending while its sampled level differs from the last level issued,
    // so toggles that cancel out before being pushed never produce an event.
    assign w_pending = r_cur ^ r_reported;
    assign w_valid   = r_count != '0;
    assign w_pop     = w_valid && i_ev_ready;
    assign w_push    = (|w_pending) && (r_count < CNT_W'(DEPTH) || w_pop);

    always_comb begin
        w_sel = '0;
        for (int i = INPUTS - 1; i >= 0; i--)
            if (w_pending[i]) w_sel = IDX_W'(i);
    end

    always_ff @(posedge i_clock) begin
        r_cur <= i_switch_db;
        if (i_reset) begin
            r_reported <= i_switch_db;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr]       <= {w_sel, r_cur[w_sel]};
                r_reported[w_sel] <= r_cur[w_sel];
                r_wr              <= r_wr + PTR_W'(1);
            end
            if (w_pop) r_rd <= r_rd + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign o_ev_valid = w_valid;
    assign o_ev_index = w_valid ? r_mem[r_rd][IDX_W:1] : '0;
    assign o_ev_level = w_valid && r_mem[r_rd][0];
    assign o_ev_count = r_count;
    assign o_state    = r_cur;
endmodule

// File: tb/tb_switch_event_queue.sv
// tb_switch_event_queue: fixed vector table, hand sequences for full/collapse/reset,
// and a randomized run checked against a queue-based reference model.
module tb_switch_event_queue;
    localparam int DEPTH = 8;

    logic        clk = 0;
    logic        i_reset = 1;
    logic [15:0] i_switch_db = '0;
    logic        i_ev_ready = 0;
    logic        o_ev_valid, o_ev_level;
    logic [3:0]  o_ev_index, o_ev_count;
    logic [15:0] o_state;

    int total = 0;
    int bad   = 0;

    logic [15:0] cur_m, rep_m;
    logic [4:0]  q[$];

    switch_event_queue dut (
        .i_clock(clk), .i_reset(i_reset), .i_switch_db(i_switch_db),
        .o_ev_valid(o_ev_valid), .i_ev_ready(i_ev_ready), .o_ev_index(o_ev_index),
        .o_ev_level(o_ev_level), .o_ev_count(o_ev_count), .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: the head event leaves on accept, then the lowest differing switch
    // is issued if there is room (or room is being made this cycle).
    task automatic model_edge(input logic [15:0] sw, input logic rdy, input logic rst);
        logic [15:0] pend;
        logic        pop, push;
        if (rst) begin
            cur_m = sw;
            rep_m = sw;
            q.delete();
            return;
        end
        pend = cur_m ^ rep_m;
        pop  = q.size() > 0 && rdy;
        push = pend != 0 && (q.size() < DEPTH || pop);
        if (pop) void'(q.pop_front());
        if (push)
            for (int i = 0; i < 16; i++)
                if (pend[i]) begin
                    q.push_back({i[3:0], cur_m[i]});
                    rep_m[i] = cur_m[i];
                    break;
                end
        cur_m = sw;
    endtask

    task automatic check_model();
        logic [4:0] head;
        head = q.size() > 0 ? q[0] : 5'd0;
        chk("model_valid", int'(o_ev_valid), int'(q.size() > 0));
        chk("model_count", int'(o_ev_count), q.size());
        chk("model_index", int'(o_ev_index), int'(head[4:1]));
        chk("model_level", int'(o_ev_level), int'(head[0]));
        chk("model_state", int'(o_state), int'(cur_m));
    endtask

    task automatic step(input logic [15:0] sw, input logic rdy, input logic rst);
        i_switch_db = sw;
        i_ev_ready  = rdy;
        i_reset     = rst;
        @(posedge clk);
        model_edge(sw, rdy, rst);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic [15:0] sw;
        logic        rdy, rst;
        logic        valid;
        logic [3:0]  index;
        logic        level;
        logic [3:0]  count;
        logic [15:0] state;
    } vec_t;

    vec_t vt[$];
    logic [15:0] sw;
    int got[$];

    initial begin
        // sw, rdy, rst -> valid, index, level, count, state
        vt.push_back('{16'h00A5, 1, 1, 0, 0, 0, 0, 16'h00A5});
        vt.push_back('{16'h00A5, 1, 0, 0, 0, 0, 0, 16'h00A5});
        vt.push_back('{16'h0000, 1, 1, 0, 0, 0, 0, 16'h0000});
        vt.push_back('{16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000});
        vt.push_back('{16'h0008, 1, 0, 0, 0, 0, 0, 16'h0008});
        vt.push_back('{16'h0008, 1, 0, 1, 3, 1, 1, 16'h0008});
        vt.push_back('{16'h0008, 1, 0, 0, 0, 0, 0, 16'h0008});
        vt.push_back('{16'h8109, 1, 0, 0, 0, 0, 0, 16'h8109});
        vt.push_back('{16'h8109, 1, 0, 1, 0, 1, 1, 16'h8109});
        vt.push_back('{16'h8109, 1, 0, 1, 8, 1, 1, 16'h8109});
        vt.push_back('{16'h8109, 1, 0, 1, 15, 1, 1, 16'h8109});
        vt.push_back('{16'h8109, 1, 0, 0, 0, 0, 0, 16'h8109});
        vt.push_back('{16'h8101, 0, 0, 0, 0, 0, 0, 16'h8101});
        vt.push_back('{16'h8101, 0, 0, 1, 3, 0, 1, 16'h8101});
        vt.push_back('{16'h8101, 0, 0, 1, 3, 0, 1, 16'h8101});
        vt.push_back('{16'h8101, 1, 0, 0, 0, 0, 0, 16'h8101});
        foreach (vt[k]) begin
            step(vt[k].sw, vt[k].rdy, vt[k].rst);
            chk($sformatf("vec%0d_valid", k), int'(o_ev_valid), int'(vt[k].valid));
            chk($sformatf("vec%0d_index", k), int'(o_ev_index), int'(vt[k].index));
            chk($sformatf("vec%0d_level", k), int'(o_ev_level), int'(vt[k].level));
            chk($sformatf("vec%0d_count", k), int'(o_ev_count), int'(vt[k].count));
            chk($sformatf("vec%0d_state", k), int'(o_state), int'(vt[k].state));
        end

        // Reset with switches held non-zero: no spurious events afterwards
        step(16'h00A5, 1, 1);
        for (int c = 0; c < 20; c++) begin
            step(16'h00A5, 1, 0);
            chk("quiet_valid", int'(o_ev_valid), 0);
            chk("quiet_state", int'(o_state), 16'h00A5);
        end

        // Fill under back-pressure, then collapse bit 12 while full, then drain
        step(16'h0000, 0, 1);
        sw = '0;
        for (int k = 0; k < 10; k++) begin
            sw[k] = 1'b1;
            step(sw, 0, 0);
        end
        for (int c = 0; c < 4; c++) step(sw, 0, 0);
        chk("full_count", int'(o_ev_count), 8);
        chk("full_head", int'(o_ev_index), 0);
        sw[12] = 1'b1;
        step(sw, 0, 0);
        sw[12] = 1'b0;
        step(sw, 0, 0);
        step(sw, 0, 0);
        chk("full_hold", int'(o_ev_count), 8);
        got.delete();
        for (int c = 0; c < 40 && got.size() < 12; c++) begin
            if (o_ev_valid) got.push_back(int'(o_ev_index));
            step(sw, 1, 0);
        end
        for (int c = 0; c < 5; c++) begin
            if (o_ev_valid) got.push_back(int'(o_ev_index));
            step(sw, 1, 0);
        end
        chk("drain_events", got.size(), 10);
        foreach (got[j]) chk($sformatf("drain_order%0d", j), got[j], j);

        // Reset with events queued discards them
        step(16'h0000, 0, 1);
        for (int c = 0; c < 8; c++) step(16'h001F, 0, 0);
        chk("five_count", int'(o_ev_count), 5);
        step(16'h0003, 0, 1);
        chk("rst_valid", int'(o_ev_valid), 0);
        chk("rst_count", int'(o_ev_count), 0);
        chk("rst_state", int'(o_state), 16'h0003);
        for (int c = 0; c < 10; c++) begin
            step(16'h0003, 1, 0);
            chk("post_rst_valid", int'(o_ev_valid), 0);
        end

        // Randomized traffic against the reference model
        sw = $urandom();
        step(sw, 0, 1);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) sw[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 40) == 0) sw ^= 16'($urandom());
            step(sw, $urandom_range(0, 2) == 0, $urandom_range(0, 300) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/switch_event_queue.md
Name: switch_event_queue

Overview:
- Sits directly downstream of the per-switch debounce stage. Consumes its INPUTS-wide debounced switch vector.
- Turns every net level change on a switch into a discrete event: the switch index plus its new level.
- Buffers events in a first-word-fall-through FIFO for the system bus / cog-facing register logic, using a valid/ready handshake.
- Never loses the current state of a switch. Under back-pressure, repeated toggles of the same switch collapse into the net change.

Parameters:
- INPUTS, 16, number of debounced switch inputs.
- IDX_W, 4, width of the event index; must satisfy 2**IDX_W >= INPUTS.
- DEPTH, 8, FIFO depth in events; power of two, at least 2.
- CNT_W, 4, width of the fill count; must satisfy 2**CNT_W > DEPTH.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- switch_db  in  INPUTS  debounced switch levels, synchronous to clock.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head event this cycle.
- ev_index  out  IDX_W  switch index of the head event.
- ev_level  out  1  new level of that switch (1 = rising/pressed, 0 = falling/released).
- ev_count  out  CNT_W  number of events currently stored.
- state  out  INPUTS  registered copy of switch_db (cur).

Behaviour:
- Registers:
  - cur[INPUTS] samples switch_db every cycle.
  - reported[INPUTS] holds the last level issued as an event per switch.
  - FIFO storage, read/write pointers, count.
- Reset (synchronous, while reset=1):
  - cur <= switch_db and reported <= switch_db, so no spurious events at reset release.
  - FIFO emptied: ev_valid=0, ev_count=0, ev_index=0, ev_level=0.
  - Reset mid-operation discards all queued and pending events.
- pending = cur XOR reported (combinational).
- Scan:
  - Each cycle, select the lowest index i with pending[i]=1.
  - push = any pending AND (count<DEPTH OR pop).
  - On push: write {i, cur[i]} to the FIFO and set reported[i] <= cur[i].
  - At most one event per cycle.
- pop = ev_valid AND ev_ready. ev_ready is ignored while ev_valid=0.
- Latency (no contention):
  - switch_db changes before edge E0; cur updates at E0.
  - The event is written at E1, and ev_valid=1 after E1 (2 cycles).
  - No combinational path from switch_db or ev_ready to any output.
- FIFO read side:
  - ev_index/ev_level reflect the head entry and stay stable while ev_valid=1 and ev_ready=0.
  - Head advances on the edge where pop=1.
- Full:
  - count==DEPTH with no pop: no push. pending bits stay set and are issued later.
  - Full with pop in the same cycle: push allowed; count unchanged.
- Empty: a simultaneous push and empty state gives no bypass; ev_valid rises the cycle after the write.
- Collapse: if cur[i] returns to reported[i] before switch i is pushed, pending[i] clears and no event is issued.
- Multiple simultaneous changes are issued in ascending index order, one per cycle.
- Pointer wrap-around is modulo DEPTH.
- ev_count = stored entries, updated as count + push - pop.

Test Plan:
1. Hold switch_db=16'h00A5 through reset, then release with ev_ready=1 for 20 cycles → ev_valid stays 0, state=16'h00A5.
2. From 0, set switch_db=16'h0008 at cycle N with ev_ready=1 → ev_valid=1 two cycles later with ev_index=3, ev_level=1. Accepted next edge; ev_count returns to 0.
3. Step switch_db 0→16'h8101 in one cycle with ev_ready=1 → three consecutive events: index 0, 8, 15, all with level 1.
4. ev_ready=0, toggle bits 0..9 high one per cycle → ev_count reaches 8 and holds. Bits 8 and 9 remain pending. Raising ev_ready drains indices 0..9 in order with no loss.
5. Queue full with ev_ready=0: set bit 12 high, then low again before space frees → no event for index 12 ever appears.
6. Queue holding 5 events: assert reset for 1 cycle with switch_db=16'h0003 → ev_valid=0 and ev_count=0 next cycle, and no events appear afterwards.
